comp_sum_arbiter: RTL and testbench
===================================

# comp_sum_arbiter

Two-requester round-robin arbiter that shares a single `comp_sum_4to1` adder among clients in the AES256 core. Each client offers four 16-bit operands under a level request. The arbiter registers the granted client's operands onto the adder inputs, waits out the adder's one-cycle registered latency, captures the 16-bit sum and carry, and returns them with a one-cycle acknowledge. Exactly one operation is in flight at a time.

## Interface
- `RR`, default 1: 1 selects round-robin; 0 selects fixed priority, where A always wins.
- `clk`  in  1  rising-edge clock, shared with the adder.
- `reset`  in  1  asynchronous, active-low reset.
- `req_a`, `req_b`  in  1 each  level request from client A / client B.
- `a_val1..a_val4`, `b_val1..b_val4`  in  16 each  client operands; must be stable while the request is high.
- `ack_a`, `ack_b`  out  1 each  one-cycle completion pulse to the owning client.
- `res`  out  16  result, valid while either ack is high.
- `res_carry`  out  1  carry, valid while either ack is high.
- `busy`  out  1  high in every state except IDLE.
- `sum_val1..sum_val4`  out  16 each  registered drive to the adder's `val1..val4`.
- `sum_out`  in  16  adder `out`.
- `sum_carry`  in  1  adder `carry`.

## Operation
- FSM states: IDLE → LOAD → CAPT → RESP → IDLE.
- **IDLE:** if either request is high, pick a winner.
  - On that edge: copy the winner's 4 operands into `sum_val1..4`, store the `owner` bit, go to LOAD.
  - With no request, stay in IDLE and hold `sum_val*`.
- **Winner selection:**
  - Only one request high: that client wins.
  - Both high and `RR=1`: the client not served last wins. `last` resets to B, so A wins the first tie.
  - Both high and `RR=0`: A wins.
  - `last` updates to `owner` on the grant edge.
- **LOAD:** unconditional → CAPT. The adder registers `sum_val*` on this edge.
- **CAPT:** on this edge, capture `sum_out` into `res` and `sum_carry` into `res_carry`, set the ack for `owner`, go to RESP.
- **RESP:** the owner's ack is high for this whole cycle. Requests are ignored. Next edge: clear ack → IDLE.
- **Arithmetic:**
  - `res` = (v1+v2+v3+v4) mod 2^16.
  - `res_carry` = bit 16 of the true sum. Bit 17 is discarded, matching the 17-bit adder.
- **Operand sampling:** operands are sampled only on the grant edge. Later changes have no effect on the operation in flight.
- **Client protocol:**
  - Sample the ack on the rising edge that ends the ack cycle.
  - To issue back-to-back operations, keep the request high and present new operands by that edge.
  - To stop, drop the request by that edge.
- **Unused outputs:** `res` and `res_carry` hold their last value outside RESP. Clients must qualify them with their ack.
- **Reset (asserted low, any state, effective immediately):**
  - state = IDLE, `last` = B, `owner` = A.
  - `ack_a` = `ack_b` = 0, `busy` = 0.
  - `res` = 0, `res_carry` = 0, `sum_val1..4` = 0.
- **Reset mid-operation:** the in-flight result is lost and no ack is issued. The adder itself has no reset; its stale register is never captured because the FSM restarts in IDLE.

## Timing
- Grant edge E0; the adder registers on E1; capture on E2; ack high from E2 to E3.
- Latency from request seen at E0 to ack: 2 edges. Ack width: exactly 1 cycle.
- Maximum throughput: 1 operation per 4 cycles. Next earliest grant is E4 for the same or the other client.
- `busy` high from just after E0 until E3.
- Ack is never asserted to both clients at once. No ack without a preceding grant.
- A request raised while busy waits. It is arbitrated at the first IDLE edge with fair rotation; no request is lost while held high.

## Test plan
- **Reset values:** hold `reset`=0 while toggling requests → all outputs 0, no ack. Release → the first tie grants A.
- **Single operation:** only A, operands 0x0001, 0x0002, 0x0003, 0x0004 at E0 → `sum_val`=1,2,3,4 after E0; `ack_a` high E2–E3; `res`=0x000A; `res_carry`=0; `busy` high E0–E3.
- **Overflow:** A sends 0xFFFF ×4 → `res`=0xFFFC, `res_carry`=1. B sends 0x8000, 0x8000, 0, 0 → `res`=0x0000, `res_carry`=1.
- **Round-robin:** `RR=1`, both requests held high for 4 operations → ack order A, B, A, B, with a 4-cycle spacing. `RR=0`, same stimulus → all acks go to A.
- **Operand stability:** change `a_val1` from 5 to 9 one cycle after the grant → the result still uses 5; the new value is used only on the next grant.
- **Mid-operation reset:** assert `reset` while in CAPT → no ack, all outputs 0 immediately. Release with `req_b` high → a normal operation completes 2 edges after the grant.

Source files
------------

// File: rtl/comp_sum_arbiter.sv
// Two-client round-robin arbiter in front of a shared registered 4-operand adder.
// Ack follows the grant by 2 edges and lasts 1 cycle; requests wait in place while busy, at most 1 op per 4 cycles.
module comp_sum_arbiter #(
    parameter logic RR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [15:0] a_val1,
    input  logic [15:0] a_val2,
    input  logic [15:0] a_val3,
    input  logic [15:0] a_val4,
    input  logic [15:0] b_val1,
    input  logic [15:0] b_val2,
    input  logic [15:0] b_val3,
    input  logic [15:0] b_val4,
    output logic        ack_a,
    output logic        ack_b,
    output logic [15:0] res,
    output logic        res_carry,
    output logic        busy,
    output logic [15:0] sum_val1,
    output logic [15:0] sum_val2,
    output logic [15:0] sum_val3,
    output logic [15:0] sum_val4,
    input  logic [15:0] sum_out,
    input  logic        sum_carry
);

    typedef enum logic [1:0] {IDLE, LOAD, CAPT, RESP} state_t;

    state_t      state;
    state_t      next_state;
    logic        owner;      // 0 = A, 1 = B
    logic        last;       // client served most recently, 0 = A, 1 = B
    logic        grant;
    logic        win_b;
    logic [15:0] op1, op2, op3, op4;

    // On a tie B wins only under round-robin when A was served last.
    assign grant = req_a | req_b;
    assign win_b = req_b & (~req_a | (RR & ~last));
    assign busy  = (state != IDLE);

    always_comb begin
        op1 = a_val1;
        op2 = a_val2;
        op3 = a_val3;
        op4 = a_val4;
        if (win_b) begin
            op1 = b_val1;
            op2 = b_val2;
            op3 = b_val3;
            op4 = b_val4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant) next_state = LOAD;
            LOAD:    next_state = CAPT;
            CAPT:    next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner     <= 1'b0;
            last      <= 1'b1;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            res       <= 16'h0000;
            res_carry <= 1'b0;
            sum_val1  <= 16'h0000;
            sum_val2  <= 16'h0000;
            sum_val3  <= 16'h0000;
            sum_val4  <= 16'h0000;
        end else begin
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner    <= win_b;
                        last     <= win_b;
                        sum_val1 <= op1;
                        sum_val2 <= op2;
                        sum_val3 <= op3;
                        sum_val4 <= op4;
                    end
                end
                // The adder registered sum_val* on the LOAD edge, so its output is valid here.
                CAPT: begin
                    res       <= sum_out;
                    res_carry <= sum_carry;
                    ack_a     <= ~owner;
                    ack_b     <= owner;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comp_sum_arbiter.sv
// Bench for comp_sum_arbiter: a round-robin and a fixed-priority instance, each with a registered adder model.
module tb_comp_sum_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_a, req_b;
    logic [15:0] a1, a2, a3, a4, b1, b2, b3, b4;

    logic        ack_a, ack_b, res_carry, busy, sum_carry;
    logic [15:0] res, sv1, sv2, sv3, sv4, sum_out;
    logic        f_ack_a, f_ack_b, f_res_carry, f_busy, f_sum_carry;
    logic [15:0] f_res, f_sv1, f_sv2, f_sv3, f_sv4, f_sum_out;
    logic [17:0] add_t, f_add_t;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    comp_sum_arbiter #(.RR(1'b1)) dut (
        .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b),
        .a_val1(a1), .a_val2(a2), .a_val3(a3), .a_val4(a4),
        .b_val1(b1), .b_val2(b2), .b_val3(b3), .b_val4(b4),
        .ack_a(ack_a), .ack_b(ack_b), .res(res), .res_carry(res_carry), .busy(busy),
        .sum_val1(sv1), .sum_val2(sv2), .sum_val3(sv3), .sum_val4(sv4),
        .sum_out(sum_out), .sum_carry(sum_carry)
    );

    comp_sum_arbiter #(.RR(1'b0)) dut_fp (
        .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b),
        .a_val1(a1), .a_val2(a2), .a_val3(a3), .a_val4(a4),
        .b_val1(b1), .b_val2(b2), .b_val3(b3), .b_val4(b4),
        .ack_a(f_ack_a), .ack_b(f_ack_b), .res(f_res), .res_carry(f_res_carry), .busy(f_busy),
        .sum_val1(f_sv1), .sum_val2(f_sv2), .sum_val3(f_sv3), .sum_val4(f_sv4),
        .sum_out(f_sum_out), .sum_carry(f_sum_carry)
    );

    // Registered 17-bit adder without reset; bit 17 dropped.
    always @(posedge clk) begin
        add_t = {2'b00, sv1} + {2'b00, sv2} + {2'b00, sv3} + {2'b00, sv4};
        sum_out   <= add_t[15:0];
        sum_carry <= add_t[16];
        f_add_t = {2'b00, f_sv1} + {2'b00, f_sv2} + {2'b00, f_sv3} + {2'b00, f_sv4};
        f_sum_out   <= f_add_t[15:0];
        f_sum_carry <= f_add_t[16];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic             ra;
        logic             rb;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic             exp_b;
        logic [15:0]      exp_res;
        logic             exp_c;
    } vec_t;

    function automatic vec_t mk(input logic ra, input logic rb,
                                input logic [15:0] x1, input logic [15:0] x2,
                                input logic [15:0] x3, input logic [15:0] x4,
                                input logic [15:0] y1, input logic [15:0] y2,
                                input logic [15:0] y3, input logic [15:0] y4,
                                input logic eb, input logic [15:0] er, input logic ec);
        vec_t v;
        v.ra = ra; v.rb = rb;
        v.a = {x4, x3, x2, x1};
        v.b = {y4, y3, y2, y1};
        v.exp_b = eb; v.exp_res = er; v.exp_c = ec;
        return v;
    endfunction

    task automatic run_op(input vec_t v, input int idx);
        logic [63:0] exp_sv;
        @(negedge clk);
        req_a = v.ra; req_b = v.rb;
        a1 = v.a[0]; a2 = v.a[1]; a3 = v.a[2]; a4 = v.a[3];
        b1 = v.b[0]; b2 = v.b[1]; b3 = v.b[2]; b4 = v.b[3];
        exp_sv = v.exp_b ? v.b : v.a;
        @(posedge clk); #1;
        check($sformatf("v%0d_sumval", idx), {sv4, sv3, sv2, sv1}, exp_sv);
        check($sformatf("v%0d_busy_e0", idx), busy, 1'b1);
        @(posedge clk); #1;
        check($sformatf("v%0d_noack_e1", idx), {ack_a, ack_b}, 2'b00);
        @(posedge clk); #1;
        check($sformatf("v%0d_ack", idx), {ack_a, ack_b}, v.exp_b ? 2'b01 : 2'b10);
        check($sformatf("v%0d_res", idx), {res_carry, res}, {v.exp_c, v.exp_res});
        check($sformatf("v%0d_busy_e2", idx), busy, 1'b1);
        @(negedge clk);
        req_a = 1'b0; req_b = 1'b0;
        @(posedge clk); #1;
        check($sformatf("v%0d_e3_idle", idx), {ack_a, ack_b, busy}, 3'b000);
        check($sformatf("v%0d_res_hold", idx), {res_carry, res}, {v.exp_c, v.exp_res});
    endtask

    vec_t vecs[7];
    int   rr_n, fp_n, dropped;
    int   rr_cyc[8], fp_cyc[8];
    logic rr_own[8], fp_own[8];
    logic [15:0] rr_res[8], fp_res[8];

    initial begin
        vecs[0] = mk(1, 1, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0009, 16'h0009, 16'h0009, 16'h0009, 0, 16'h000A, 0);
        vecs[1] = mk(1, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'hFFFC, 1);
        vecs[2] = mk(0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 1, 16'h0000, 1);
        vecs[3] = mk(0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h1111, 16'h0001, 16'h0002, 1, 16'h2348, 0);
        vecs[4] = mk(1, 1, 16'd10, 16'd20, 16'd30, 16'd40, 16'h0005, 16'h0005, 16'h0005, 16'h0005, 0, 16'h0064, 0);
        vecs[5] = mk(1, 1, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 1, 16'h8000, 0);
        vecs[6] = mk(1, 0, 16'hC000, 16'hC000, 16'hC000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h8000, 0);

        reset = 1'b0; req_a = 1'b0; req_b = 1'b0;
        a1 = 0; a2 = 0; a3 = 0; a4 = 0; b1 = 0; b2 = 0; b3 = 0; b4 = 0;

        // Reset held while requests toggle.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_a = i[0]; req_b = i[1];
            a1 = 16'h1111; b1 = 16'h2222;
            @(posedge clk); #1;
            check($sformatf("rst_outs%0d", i), {ack_a, ack_b, busy, res_carry, res, sv1, sv2, sv3, sv4} == 0, 1'b1);
        end
        check("rst_fp_outs", {f_ack_a, f_ack_b, f_busy, f_res, f_sv1}, 0);
        @(negedge clk);
        req_a = 1'b0; req_b = 1'b0;
        reset = 1'b1;

        for (int i = 0; i < 7; i++) run_op(vecs[i], i);

        // Continuous tie from a fresh reset: RR alternates, fixed priority stays on A.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        a1 = 1; a2 = 1; a3 = 1; a4 = 1; b1 = 2; b2 = 2; b3 = 2; b4 = 2;
        req_a = 1'b1; req_b = 1'b1;
        rr_n = 0; fp_n = 0; dropped = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(posedge clk); #1;
            if ((ack_a | ack_b) && rr_n < 8) begin
                rr_own[rr_n] = ack_b; rr_cyc[rr_n] = cyc; rr_res[rr_n] = res; rr_n++;
            end
            if ((f_ack_a | f_ack_b) && fp_n < 8) begin
                fp_own[fp_n] = f_ack_b; fp_cyc[fp_n] = cyc; fp_res[fp_n] = f_res; fp_n++;
            end
            if (rr_n == 4 && dropped == 0) begin
                dropped = 1;
                @(negedge clk);
                req_a = 1'b0; req_b = 1'b0;
            end
        end
        check("rr_count", rr_n, 4);
        check("fp_count", fp_n, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_owner%0d", k), rr_own[k], k[0]);
            check($sformatf("rr_res%0d", k), rr_res[k], k[0] ? 16'd8 : 16'd4);
            check($sformatf("rr_cyc%0d", k), rr_cyc[k], 2 + 4 * k);
            check($sformatf("fp_owner%0d", k), fp_own[k], 1'b0);
            check($sformatf("fp_res%0d", k), fp_res[k], 16'd4);
            check($sformatf("fp_cyc%0d", k), fp_cyc[k], 2 + 4 * k);
        end

        // Operand change after the grant edge must not affect the op in flight.
        @(negedge clk);
        req_a = 1'b1; req_b = 1'b0;
        a1 = 16'd5; a2 = 0; a3 = 0; a4 = 0;
        @(posedge clk); #1;
        @(negedge clk);
        a1 = 16'd9;
        @(posedge clk); #1;
        check("stab_sv1_held", sv1, 16'd5);
        @(posedge clk); #1;
        check("stab_res_old", {ack_a, res}, {1'b1, 16'd5});
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("stab_sv1_new", sv1, 16'd9);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("stab_res_new", {ack_a, res}, {1'b1, 16'd9});
        @(negedge clk);
        req_a = 1'b0;
        @(posedge clk); #1;

        // Reset during CAPT: nothing acked, then B completes normally.
        @(negedge clk);
        req_a = 1'b1;
        a1 = 16'h0100; a2 = 16'h0200; a3 = 0; a4 = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_busy_capt", busy, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_zero", {ack_a, ack_b, busy, res_carry, res, sv1, sv2, sv3, sv4} == 0, 1'b1);
        req_a = 1'b0; req_b = 1'b1;
        b1 = 16'h0011; b2 = 16'h0022; b3 = 16'h0033; b4 = 16'h0044;
        @(posedge clk); #1;
        check("mid_rst_noack", {ack_a, ack_b, busy}, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_grant_b", {busy, sv4, sv3, sv2, sv1}, {1'b1, 16'h0044, 16'h0033, 16'h0022, 16'h0011});
        @(posedge clk); #1;
        check("mid_noack_e1", {ack_a, ack_b}, 2'b00);
        @(posedge clk); #1;
        check("mid_ack_b", {ack_a, ack_b, res_carry, res}, {2'b01, 1'b0, 16'h00AA});
        @(negedge clk);
        req_b = 1'b0;
        @(posedge clk); #1;
        check("mid_ack_clr", {ack_a, ack_b, busy}, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
